// File: rtl/m10k_write_sram0_pkg.sv
// Shared SpMV definitions for the SRAM0 (M10K) access FSMs: state codes,
// slot addresses and line geometry.
package m10k_write_sram0_pkg;

    localparam int SPMV_ELEM_W  = 16;
    localparam int SPMV_LANES   = 16;
    localparam int SPMV_ADDR_W  = 5;
    localparam int SPMV_IV_ADDR = 16;
    localparam int SPMV_MV_ADDR = 17;

    // Same encodings as the SRAM0 read FSM so o_state can be probed uniformly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } sram0_state_e;

    typedef enum logic {
        TGT_IV = 1'b0,
        TGT_MV = 1'b1
    } sram0_tgt_e;

endpackage

// File: rtl/m10k_write_sram0.sv
// SRAM0 write-side packer: gathers up to LANES elements into one line and
// commits it to the input-vector or matrix-value slot in a single write cycle.
module m10k_write_sram0
    import m10k_write_sram0_pkg::*;
#(
    parameter int ELEM_W  = SPMV_ELEM_W,
    parameter int LANES   = SPMV_LANES,
    parameter int ADDR_W  = SPMV_ADDR_W,
    parameter int IV_ADDR = SPMV_IV_ADDR,
    parameter int MV_ADDR = SPMV_MV_ADDR
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_write_start_IV,
    input  logic                    i_write_start_MV,
    input  logic                    i_data_valid,
    input  logic [ELEM_W-1:0]       i_data,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic                    o_write_en,
    output logic [ADDR_W-1:0]       o_write_addr,
    output logic [ELEM_W*LANES-1:0] o_write_data,
    output logic                    o_done,
    output logic [1:0]              o_state
);

    localparam int CNT_W = $clog2(LANES);

    sram0_state_e                 state_q, state_d;
    sram0_tgt_e                   tgt_q, tgt_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LANES-1:0][ELEM_W-1:0] buf_q, buf_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_IV;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                // IV has priority when both starts arrive together.
                if (i_write_start_IV || i_write_start_MV) begin
                    state_d = ST_FILL;
                    tgt_d   = i_write_start_IV ? TGT_IV : TGT_MV;
                    cnt_d   = '0;
                    buf_d   = '0;
                end
            end
            ST_FILL: begin
                if (i_data_valid) begin
                    buf_d[cnt_q] = i_data;
                    cnt_d        = cnt_q + 1'b1;
                    if (i_last || cnt_q == CNT_W'(LANES - 1))
                        state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign o_ready      = (state_q == ST_FILL);
    assign o_write_en   = (state_q == ST_WRITE);
    assign o_done       = (state_q == ST_DONE);
    assign o_state      = state_q;
    assign o_write_data = buf_q;
    // Address is only driven during the write strobe so idle bus is quiet.
    assign o_write_addr = (state_q != ST_WRITE) ? '0 :
                          (tgt_q == TGT_MV)     ? ADDR_W'(MV_ADDR) : ADDR_W'(IV_ADDR);

endmodule

// File: tb/tb_m10k_write_sram0.sv
// Directed bench for the SRAM0 write packer: a line-level model queues the
// expected SRAM writes and a per-cycle monitor checks every write and done pulse.
module tb_m10k_write_sram0;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         s_iv = 1'b0, s_mv = 1'b0, dv = 1'b0, last = 1'b0;
    logic [15:0]  din = '0;
    logic         rdy, we, done;
    logic [4:0]   waddr;
    logic [255:0] wdata;
    logic [1:0]   st;

    m10k_write_sram0 dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_write_start_IV(s_iv), .i_write_start_MV(s_mv),
        .i_data_valid(dv), .i_data(din), .i_last(last),
        .o_ready(rdy), .o_write_en(we), .o_write_addr(waddr),
        .o_write_data(wdata), .o_done(done), .o_state(st)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Line-level model: elements collected for the current line and its slot.
    logic [15:0]  mline [16];
    int           mcnt = 0;
    logic [4:0]   maddr = '0;
    logic [255:0] expq_d[$];
    logic [4:0]   expq_a[$];
    bit           exp_done = 1'b0;

    function automatic logic [255:0] packl();
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = mline[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input bit iv, input bit mv, input logic [4:0] a);
        s_iv = iv; s_mv = mv;
        tick();
        s_iv = 1'b0; s_mv = 1'b0;
        for (int i = 0; i < 16; i++) mline[i] = '0;
        mcnt  = 0;
        maddr = a;
    endtask

    task automatic send(input logic [15:0] d, input bit l, input bit commit);
        mline[mcnt] = d;
        mcnt++;
        if (commit) begin
            expq_d.push_back(packl());
            expq_a.push_back(maddr);
        end
        dv = 1'b1; din = d; last = l;
        tick();
        dv = 1'b0; last = 1'b0;
    endtask

    task automatic finish_line();
        chk("state_write", 256'(st), 256'(2'b10));
        chk("ready_write", 256'(rdy), 256'(1'b0));
        tick();
        chk("state_done", 256'(st), 256'(2'b11));
        tick();
        chk("state_idle", 256'(st), 256'(2'b00));
    endtask

    // Monitor: every write must match the queued line; done follows one cycle later.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_done = 1'b0;
        end else begin
            chk("done_pulse", 256'(done), 256'(exp_done));
            exp_done = 1'b0;
            if (we) begin
                chk("write_expected", 256'(expq_d.size() != 0), 256'(1'b1));
                if (expq_d.size() != 0) begin
                    chk("wr_addr", 256'(waddr), 256'(expq_a.pop_front()));
                    chk("wr_data", wdata, expq_d.pop_front());
                end
                exp_done = 1'b1;
            end
        end
    end

    initial begin
        logic [255:0] prev;
        #12;
        chk("rst_state", 256'(st), 256'(2'b00));
        chk("rst_ready", 256'(rdy), 256'(1'b0));
        chk("rst_we", 256'(we), 256'(1'b0));
        chk("rst_addr", 256'(waddr), 256'(5'd0));
        chk("rst_data", wdata, 256'(0));
        chk("rst_done", 256'(done), 256'(1'b0));
        rstn = 1'b1;
        tick();

        // Full IV line, back-to-back elements 1..16.
        start_line(1'b1, 1'b0, 5'd16);
        chk("fill_state", 256'(st), 256'(2'b01));
        chk("fill_ready", 256'(rdy), 256'(1'b1));
        for (int i = 0; i < 16; i++) send(16'(i + 1), 1'b0, i == 15);
        chk("iv_full_lit", wdata,
            256'h0010000f000e000d000c000b000a00090008000700060005000400030002_0001);
        chk("iv_addr_lit", 256'(waddr), 256'(5'd16));
        finish_line();

        // MV line with a one-cycle gap after every element.
        start_line(1'b0, 1'b1, 5'd17);
        for (int i = 0; i < 16; i++) begin
            send(16'(16'hA000 + i), 1'b0, i == 15);
            if (i < 15) begin
                chk("ready_gap", 256'(rdy), 256'(1'b1));
                tick();
            end
        end
        chk("mv_addr_lit", 256'(waddr), 256'(5'd17));
        finish_line();

        // Partial line closed by i_last on the 5th element.
        start_line(1'b1, 1'b0, 5'd16);
        for (int k = 1; k <= 5; k++) send(16'(k * 'h1111), k == 5, k == 5);
        chk("partial_lit", wdata, 256'h5555_4444_3333_2222_1111);
        finish_line();

        // Both starts together -> IV; MV start mid-FILL ignored.
        start_line(1'b1, 1'b1, 5'd16);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) s_mv = 1'b1;
            send(16'(i * 'h0101), 1'b0, i == 15);
            s_mv = 1'b0;
        end
        chk("both_start_addr", 256'(waddr), 256'(5'd16));
        finish_line();

        // Stray inputs while idle.
        prev = packl();
        for (int i = 0; i < 3; i++) begin
            dv = 1'b1; din = 16'hDEAD; last = (i == 1);
            tick();
            chk("idle_ready", 256'(rdy), 256'(1'b0));
            chk("idle_state", 256'(st), 256'(2'b00));
            chk("idle_data", wdata, prev);
        end
        dv = 1'b0; last = 1'b1;
        tick();
        last = 1'b0;
        chk("idle_last_state", 256'(st), 256'(2'b00));

        // i_last without valid inside FILL is ignored.
        start_line(1'b1, 1'b0, 5'd16);
        send(16'h0A0A, 1'b0, 1'b0);
        send(16'h0B0B, 1'b0, 1'b0);
        last = 1'b1;
        tick();
        last = 1'b0;
        chk("last_no_valid", 256'(st), 256'(2'b01));
        chk("last_no_valid_data", wdata, 256'h0B0B_0A0A);
        send(16'h0C0C, 1'b1, 1'b1);
        finish_line();

        // Async reset after 8 elements: no write, immediate clear.
        start_line(1'b1, 1'b0, 5'd16);
        for (int i = 0; i < 8; i++) send(16'(16'h7700 + i), 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_fill_state", 256'(st), 256'(2'b00));
        chk("arst_fill_ready", 256'(rdy), 256'(1'b0));
        chk("arst_fill_data", wdata, 256'(0));
        tick();
        rstn = 1'b1;

        // Async reset during WRITE drops the strobe without a clock edge.
        start_line(1'b0, 1'b1, 5'd17);
        for (int i = 0; i < 16; i++) send(16'(16'h3300 + i), 1'b0, 1'b0);
        chk("we_in_write", 256'(we), 256'(1'b1));
        rstn = 1'b0;
        #1;
        chk("arst_we", 256'(we), 256'(1'b0));
        chk("arst_addr", 256'(waddr), 256'(5'd0));
        chk("arst_state", 256'(st), 256'(2'b00));
        tick();
        rstn = 1'b1;

        // Next MV line carries no residue of the discarded data.
        start_line(1'b0, 1'b1, 5'd17);
        send(16'h0F01, 1'b0, 1'b0);
        send(16'h0F02, 1'b0, 1'b0);
        send(16'h0F03, 1'b1, 1'b1);
        chk("post_rst_lit", wdata, 256'h0F03_0F02_0F01);
        finish_line();

        tick();
        tick();
        chk("pending_writes", 256'(expq_d.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/m10k_write_sram0.md
# m10k_write_sram0

Write-side packer for SRAM0 (M10K, 256-bit words). Accepts a stream of 16-bit elements, packs 16 of them into one 256-bit line and commits that line in a single write cycle. The line goes to the input-vector slot (address 16) or the matrix-value slot (address 17). Lane i of a line holds element i at bits [i*16 +: 16], which is the lane order the SpMV read path uses when it serializes by count%16.

## Interface
Parameters:
- ELEM_W, 16, element width in bits
- LANES, 16, elements per SRAM line (line width = ELEM_W*LANES = 256)
- ADDR_W, 5, SRAM0 address width
- IV_ADDR, 16, line address for the input vector
- MV_ADDR, 17, line address for matrix values

Ports:
- i_clk  in  1  single clock; all state changes on the rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_write_start_IV  in  1  start filling an input-vector line; sampled in IDLE only
- i_write_start_MV  in  1  start filling a matrix-value line; sampled in IDLE only
- i_data_valid  in  1  element present on i_data
- i_data  in  16  element value
- i_last  in  1  qualifies the current valid element as the final one; commits a partial line
- o_ready  out  1  element accepted this cycle when i_data_valid=1
- o_write_en  out  1  SRAM0 write strobe
- o_write_addr  out  5  SRAM0 write address
- o_write_data  out  256  packed line
- o_done  out  1  one-cycle completion pulse
- o_state  out  2  current FSM state

## Operation
- States and 2-bit encodings: IDLE=00, FILL=01, WRITE=10, DONE=11.
- IDLE:
  - i_write_start_IV → FILL with target IV_ADDR.
  - Otherwise i_write_start_MV → FILL with target MV_ADDR.
  - If both starts are high, IV wins.
  - On the start edge: line buffer cleared to 0, lane counter cleared to 0.
- FILL:
  - o_ready=1.
  - Element accepted when i_data_valid=1: buffer[cnt*16 +: 16] ← i_data, then cnt ← cnt+1.
  - Go to WRITE when the accepted element is lane 15, or when i_last=1 with the element. Lanes not written in a partial line stay 0.
  - i_last without i_data_valid is ignored.
- WRITE: lasts one cycle.
  - o_write_en=1, o_write_addr=target, o_write_data=buffer.
  - Then go to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Starts outside IDLE are ignored.
- i_data_valid outside FILL is ignored, and the buffer is unchanged.
- The lane counter is 4 bits. It is never used past 15 because lane 15 forces WRITE.
- The target register is 1 bit (IV/MV), decoded to IV_ADDR/MV_ADDR.

## Timing
- Reset values:
  - state=IDLE, buffer=0, cnt=0, target=IV.
  - o_ready=0, o_write_en=0, o_write_addr=0, o_write_data=0, o_done=0, o_state=00.
- Output derivation:
  - o_ready, o_write_en, o_done and o_state decode the registered state only.
  - o_write_addr = target while in WRITE, otherwise 0.
  - o_write_data is the registered buffer at all times.
- Latency: start at edge 0 → FILL in cycle 1. Sixteen back-to-back valid elements are accepted at edges 1..16. WRITE is in cycle 17, DONE in cycle 18, IDLE in cycle 19.
- Minimum turnaround: one line every 19 cycles at full element rate. A new start is sampled in IDLE only.
- Gaps in i_data_valid stall FILL indefinitely. There is no timeout.
- Asynchronous reset mid-FILL or mid-WRITE:
  - Returns everything to reset values immediately.
  - o_write_en drops without waiting for a clock edge.
  - The partial line is discarded.

## Structure
- Shared SpMV package:
  - state encodings IDLE/FILL/WRITE/DONE (the same 2-bit values as the SRAM0 read FSM);
  - IV_ADDR/MV_ADDR constants;
  - ELEM_W and LANES.
- Single module. No sub-module: the lane write is an indexed part-select on the buffer register.

## Test plan
- Full IV line: start_IV, then elements 0x0001..0x0010 back-to-back → exactly one o_write_en cycle, addr 16, data lane i = i+1, o_done one cycle later, IDLE next.
- MV line with gaps: start_MV, 16 elements 0xA000+i with valid toggling every other cycle → write at addr 17 with correct lanes; o_ready holds 1 throughout FILL.
- Partial line: start_IV, 5 elements 0x1111..0x5555 with i_last on the 5th → write at addr 16; lanes 0–4 set, lanes 5–15 = 0.
- Simultaneous starts: both starts high in IDLE → target addr 16. A start_MV pulsed during FILL → no effect; the write still goes to addr 16.
- Stray input: i_data_valid, and i_last with valid low, while IDLE or in FILL → no writes, buffer unchanged, o_ready=0 in IDLE.
- Reset: i_rstn pulled low after 8 elements accepted → outputs return to reset values asynchronously, no write issued. Next start_MV produces a line with no residue of the old data.
